// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH programmable integer clock dividers sharing clock I.
//
// Ports:
//   I        single clock; state updates on its rising edge (N=1 gate on falling edge)
//   CLR_N    asynchronous active-low reset
//   CE       per-channel run enable, asynchronous to I, synchronised internally
//   ALIGN    synchronous phase restart of all running channels
//   DIV_WE   divisor write strobe, DIV_SEL selects the channel, DIV_VAL the value
//   O        divided clock outputs (registered, or I gated for a divisor of 1)
//   TC       high during the last cycle of each period
//   RUN      channel-running status
//   DIV_ACK  one-cycle pulse when a pending divisor takes effect
module clk_div_bank #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DIV_WIDTH      = 8,
    parameter int unsigned DEFAULT_DIV    = 2,
    parameter int unsigned CE_SYNC_STAGES = 2,
    localparam int unsigned SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 I,
    input  logic                 CLR_N,
    input  logic [NUM_CH-1:0]    CE,
    input  logic                 ALIGN,
    input  logic                 DIV_WE,
    input  logic [SEL_W-1:0]     DIV_SEL,
    input  logic [DIV_WIDTH-1:0] DIV_VAL,
    output logic [NUM_CH-1:0]    O,
    output logic [NUM_CH-1:0]    TC,
    output logic [NUM_CH-1:0]    RUN,
    output logic [NUM_CH-1:0]    DIV_ACK
);

    localparam int unsigned NSYNC = CE_SYNC_STAGES + 1;
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DEF_DIV =
        (DEFAULT_DIV == 0) ? ONE : DIV_WIDTH'(DEFAULT_DIV);

    // CE synchroniser: stage NSYNC-1 is the value the channels act on.
    logic [NUM_CH-1:0] sync_q [NSYNC];
    logic [NUM_CH-1:0] sync_d [NSYNC];
    logic [NUM_CH-1:0] ce_s;

    always_comb begin
        sync_d[0] = CE;
        for (int k = 1; k < int'(NSYNC); k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    always_ff @(posedge I or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int k = 0; k < int'(NSYNC); k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NSYNC); k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    assign ce_s = sync_q[NSYNC-1];

    // Per-channel state.
    logic [DIV_WIDTH-1:0] n_q   [NUM_CH];
    logic [DIV_WIDTH-1:0] n_d   [NUM_CH];
    logic [DIV_WIDTH-1:0] p_q   [NUM_CH];
    logic [DIV_WIDTH-1:0] p_d   [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_d [NUM_CH];
    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [NUM_CH-1:0]    run_q,  run_d;
    logic [NUM_CH-1:0]    o_q,    o_d;
    logic [NUM_CH-1:0]    ack_q,  ack_d;
    logic [NUM_CH-1:0]    g_q;

    logic [DIV_WIDTH-1:0] wr_val;
    assign wr_val = (DIV_VAL == '0) ? ONE : DIV_VAL;

    always_comb begin
        logic                 wr_hit;
        logic                 pend_v;
        logic [DIV_WIDTH-1:0] pval_v;
        logic                 wrap;
        logic                 apply;
        logic [DIV_WIDTH:0]   half;

        pend_d = pend_q;
        run_d  = run_q;
        o_d    = o_q;
        ack_d  = '0;
        wr_hit = 1'b0;
        pend_v = 1'b0;
        pval_v = '0;
        wrap   = 1'b0;
        apply  = 1'b0;
        half   = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            // A write landing on the apply edge is folded in, so the newest value wins.
            wr_hit = DIV_WE && (DIV_SEL == SEL_W'(c));
            pend_v = pend_q[c] | wr_hit;
            pval_v = wr_hit ? wr_val : p_q[c];
            wrap   = (cnt_q[c] == n_q[c] - ONE);
            half   = ({1'b0, n_q[c]} + 1'b1) >> 1;
            apply  = 1'b0;

            n_d[c]    = n_q[c];
            p_d[c]    = pval_v;
            pend_d[c] = pend_v;
            cnt_d[c]  = cnt_q[c];

            if (!run_q[c]) begin
                apply    = 1'b1;
                cnt_d[c] = '0;
                run_d[c] = ce_s[c];
                o_d[c]   = ce_s[c];
            end else if (ALIGN) begin
                // Restart takes precedence over wrap and over a pending stop.
                apply    = 1'b1;
                cnt_d[c] = '0;
                o_d[c]   = 1'b1;
            end else if (wrap) begin
                apply    = 1'b1;
                cnt_d[c] = '0;
                run_d[c] = ce_s[c];
                o_d[c]   = ce_s[c];
            end else begin
                cnt_d[c] = cnt_q[c] + ONE;
                o_d[c]   = ({1'b0, cnt_d[c]} < half);
            end

            if (apply && pend_v) begin
                n_d[c]    = pval_v;
                pend_d[c] = 1'b0;
                ack_d[c]  = 1'b1;
            end
        end
    end

    always_ff @(posedge I or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                n_q[c]   <= DEF_DIV;
                p_q[c]   <= DEF_DIV;
                cnt_q[c] <= '0;
            end
            pend_q <= '0;
            run_q  <= '0;
            o_q    <= '0;
            ack_q  <= '0;
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                n_q[c]   <= n_d[c];
                p_q[c]   <= p_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            pend_q <= pend_d;
            run_q  <= run_d;
            o_q    <= o_d;
            ack_q  <= ack_d;
        end
    end

    // Gate for divide-by-1: sampled while I is low so I AND g never chops a pulse.
    always_ff @(negedge I or negedge CLR_N) begin
        if (!CLR_N) begin
            g_q <= '0;
        end else begin
            g_q <= run_q;
        end
    end

    always_comb begin
        O  = '0;
        TC = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            O[c]  = (n_q[c] == ONE) ? (I & g_q[c]) : o_q[c];
            TC[c] = run_q[c] & (cnt_q[c] == n_q[c] - ONE);
        end
    end

    assign RUN     = run_q;
    assign DIV_ACK = ack_q;

endmodule
